// File: rtl/mips_mc_ctrl_pkg.sv
// mips_pkg: shared types and constants for the multicycle MIPS control unit.
//   state_t       - controller state encoding (also exported on state_o)
//   OP_* / FN_*   - opcode and R-type funct values that the controller decodes
//   ALU_*         - ALU function codes driven on alu_sel
//   SRCA_*/SRCB_* - ALU operand mux selects
//   PCSRC_*       - PC source mux selects
//   CAUSE_*       - exception cause codes
// Helpers: is_mem_state, funct_valid, funct_alu.
package mips_pkg;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC,
        RWB, ADDI_EX, IWB, BRANCH, BRANCH_NE, JUMP, EXC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_A      = 1'b1;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;

    // States that touch memory and therefore stretch by the wait count.
    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

    function automatic logic funct_valid(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_XOR);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: bundle between the multicycle controller and the datapath.
//   Datapath -> controller: opcode, funct, alu_zero, alu_overflow.
//   Controller -> datapath: register loads, mux selects, ALU function,
//   memory control, EPC/Cause capture and the debug state_o.
// Modports: master = controller side, slave = datapath side.
interface mips_mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_overflow;

    logic       pc_write;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_load;
    logic       a_load;
    logic       b_load;
    logic       aluout_load;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic [1:0] pc_source;
    logic       epc_load;
    logic       cause_load;
    logic [1:0] cause;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, alu_zero, alu_overflow,
        output pc_write, iord, mem_wr, ir_write, mdr_load, a_load, b_load,
               aluout_load, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_sel, pc_source, epc_load, cause_load, cause,
               state_o
    );

    modport slave (
        output opcode, funct, alu_zero, alu_overflow,
        input  pc_write, iord, mem_wr, ir_write, mdr_load, a_load, b_load,
               aluout_load, reg_write, reg_dst, mem_to_reg, alu_src_a,
               alu_src_b, alu_sel, pc_source, epc_load, cause_load, cause,
               state_o
    );
endinterface

// File: rtl/mips_mc_ctrl_wait.sv
// mips_mc_wait: memory wait-state counter.
//   Clk  - clock
//   clr  - synchronous clear (state entry or reset)
//   en   - count while in a memory state; saturates once done
//   done - counter has reached MEM_WAIT (memory access completes this cycle)
module mips_mc_wait #(
    parameter int MEM_WAIT = 1,
    parameter int WAIT_W   = 4
) (
    input  logic Clk,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [WAIT_W-1:0] cnt;

    assign done = (cnt == WAIT_W'(MEM_WAIT));

    always_ff @(posedge Clk) begin
        if (clr)
            cnt <= '0;
        else if (en && !done)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control unit (Moore FSM, Mealy branch PC write).
//   Clk   - clock, all state changes on the rising edge
//   reset - synchronous active-high reset, forces RST
//   bus   - mips_mc_ctrl_if.master: opcode/funct/ALU flags in, all datapath
//           enables, selects, EPC/Cause control and state_o out
// Parameters: MEM_WAIT extra cycles per memory access, WAIT_W counter width.
// Build option: MIPS_BNE_EN adds bne (opcode 0x05); otherwise 0x05 traps as
// an illegal opcode.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int WAIT_W   = 4
) (
    input  logic            Clk,
    input  logic            reset,
    mips_mc_ctrl_if.master  bus
);
    state_t     state, state_n;
    logic [1:0] cause_q, cause_n;
    logic       wait_clr, wait_done;

    // Counter restarts whenever a memory state is entered from another state.
    assign wait_clr = reset || (is_mem_state(state_n) && (state_n != state));

    mips_mc_wait #(.MEM_WAIT(MEM_WAIT), .WAIT_W(WAIT_W)) u_wait (
        .Clk  (Clk),
        .clr  (wait_clr),
        .en   (is_mem_state(state)),
        .done (wait_done)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state   <= RST;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_n;
            cause_q <= cause_n;
        end
    end

    assign bus.state_o = state;

    always_comb begin
        state_n          = state;
        cause_n          = cause_q;
        bus.pc_write     = 1'b0;
        bus.iord         = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mdr_load     = 1'b0;
        bus.a_load       = 1'b0;
        bus.b_load       = 1'b0;
        bus.aluout_load  = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.alu_src_a    = SRCA_PC;
        bus.alu_src_b    = SRCB_B;
        bus.alu_sel      = ALU_NONE;
        bus.pc_source    = PCSRC_ALU;
        bus.epc_load     = 1'b0;
        bus.cause_load   = 1'b0;
        bus.cause        = CAUSE_NONE;

        case (state)
            RST: state_n = FETCH;

            FETCH: begin
                bus.alu_src_b = SRCB_4;
                bus.alu_sel   = ALU_ADD;
                if (wait_done) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_n      = DECODE;
                end
            end

            // Branch target (PC + imm<<2) is computed speculatively here.
            DECODE: begin
                bus.a_load      = 1'b1;
                bus.b_load      = 1'b1;
                bus.alu_src_b   = SRCB_IMM_SH;
                bus.alu_sel     = ALU_ADD;
                bus.aluout_load = 1'b1;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (funct_valid(bus.funct)) begin
                            state_n = EXEC;
                        end else begin
                            state_n = EXC;
                            cause_n = CAUSE_ILL;
                        end
                    end
                    OP_LW, OP_SW: state_n = MEMADDR;
                    OP_BEQ:       state_n = BRANCH;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_n = BRANCH_NE;
`endif
                    OP_J:         state_n = JUMP;
                    OP_ADDI:      state_n = ADDI_EX;
                    default: begin
                        state_n = EXC;
                        cause_n = CAUSE_ILL;
                    end
                endcase
            end

            MEMADDR: begin
                bus.alu_src_a   = SRCA_A;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_sel     = ALU_ADD;
                bus.aluout_load = 1'b1;
                state_n         = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end

            MEMREAD: begin
                bus.iord = 1'b1;
                if (wait_done) begin
                    bus.mdr_load = 1'b1;
                    state_n      = MEMWB;
                end
            end

            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_n        = FETCH;
            end

            MEMWRITE: begin
                bus.iord   = 1'b1;
                bus.mem_wr = 1'b1;
                if (wait_done)
                    state_n = FETCH;
            end

            EXEC: begin
                bus.alu_src_a   = SRCA_A;
                bus.alu_src_b   = SRCB_B;
                bus.alu_sel     = funct_alu(bus.funct);
                bus.aluout_load = 1'b1;
                // Logical ops cannot overflow; the flag is ignored for them.
                if (bus.alu_overflow && (bus.funct == FN_ADD || bus.funct == FN_SUB)) begin
                    state_n = EXC;
                    cause_n = CAUSE_OVF;
                end else begin
                    state_n = RWB;
                end
            end

            RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_n       = FETCH;
            end

            ADDI_EX: begin
                bus.alu_src_a   = SRCA_A;
                bus.alu_src_b   = SRCB_IMM;
                bus.alu_sel     = ALU_ADD;
                bus.aluout_load = 1'b1;
                if (bus.alu_overflow) begin
                    state_n = EXC;
                    cause_n = CAUSE_OVF;
                end else begin
                    state_n = IWB;
                end
            end

            IWB: begin
                bus.reg_write = 1'b1;
                state_n       = FETCH;
            end

            // The only Mealy output: PC write follows the live zero flag.
            BRANCH, BRANCH_NE: begin
                bus.alu_src_a = SRCA_A;
                bus.alu_src_b = SRCB_B;
                bus.alu_sel   = ALU_SUB;
                bus.pc_source = PCSRC_ALUOUT;
                bus.pc_write  = (state == BRANCH) ? bus.alu_zero : !bus.alu_zero;
                state_n       = FETCH;
            end

            JUMP: begin
                bus.pc_source = PCSRC_JUMP;
                bus.pc_write  = 1'b1;
                state_n       = FETCH;
            end

            // PC already points past the faulting instruction; ALU backs it
            // up by 4 so EPC captures the faulting address.
            EXC: begin
                bus.alu_src_b  = SRCB_4;
                bus.alu_sel    = ALU_SUB;
                bus.epc_load   = 1'b1;
                bus.cause_load = 1'b1;
                bus.cause      = cause_q;
                bus.pc_source  = PCSRC_EXC;
                bus.pc_write   = 1'b1;
                state_n        = FETCH;
            end

            default: state_n = RST;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for mips_mc_ctrl.
// The driver builds each instruction's cycle-by-cycle phase list from the
// per-class timing rules, drives opcode/funct/flags, and queues the expected
// control word for every cycle; a negedge monitor pops and compares.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    localparam int W = 1;

    logic Clk   = 1'b0;
    logic reset = 1'b1;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.MEM_WAIT(W), .WAIT_W(4)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, iord, mem_wr, ir_write, mdr_load, a_load, b_load;
        logic       aluout_load, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic [1:0] pc_source;
        logic       epc_load, cause_load;
        logic [1:0] cause;
    } cw_t;

    typedef struct {
        state_t st;
        bit     fin;
    } ph_t;

    cw_t exp_q[$];
    int  vectors    = 0;
    int  miscompares = 0;
    int  cyc        = 0;

    // Expected outputs for one cycle of a given phase (unlisted outputs are 0).
    function automatic cw_t exp_cw(state_t st, bit fin, bit zero, logic [5:0] fn, logic [1:0] cs);
        cw_t c = '0;
        c.st = 4'(st);
        case (st)
            FETCH:    begin c.alu_src_b = 2'b01; c.alu_sel = 3'b001; c.ir_write = fin; c.pc_write = fin; end
            DECODE:   begin c.a_load = 1; c.b_load = 1; c.alu_src_b = 2'b11; c.alu_sel = 3'b001; c.aluout_load = 1; end
            MEMADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_sel = 3'b001; c.aluout_load = 1; end
            MEMREAD:  begin c.iord = 1; c.mdr_load = fin; end
            MEMWB:    begin c.reg_write = 1; c.mem_to_reg = 1; end
            MEMWRITE: begin c.iord = 1; c.mem_wr = 1; end
            EXEC: begin
                c.alu_src_a = 1; c.aluout_load = 1;
                c.alu_sel = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
                            (fn == 6'h24) ? 3'b011 : 3'b110;
            end
            RWB:       begin c.reg_write = 1; c.reg_dst = 1; end
            ADDI_EX:   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_sel = 3'b001; c.aluout_load = 1; end
            IWB:       c.reg_write = 1;
            BRANCH:    begin c.alu_src_a = 1; c.alu_sel = 3'b010; c.pc_source = 2'b01; c.pc_write = zero; end
            BRANCH_NE: begin c.alu_src_a = 1; c.alu_sel = 3'b010; c.pc_source = 2'b01; c.pc_write = !zero; end
            JUMP:      begin c.pc_source = 2'b10; c.pc_write = 1; end
            EXC: begin
                c.alu_src_b = 2'b01; c.alu_sel = 3'b010; c.epc_load = 1; c.cause_load = 1;
                c.cause = cs; c.pc_source = 2'b11; c.pc_write = 1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic cw_t rst_cw();
        cw_t c = '0;
        c.st = 4'(RST);
        return c;
    endfunction

    // Monitor: one control word is presented every cycle.
    always @(negedge Clk) begin
        cw_t a, e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: bus.state_o, pc_write: bus.pc_write, iord: bus.iord, mem_wr: bus.mem_wr,
                  ir_write: bus.ir_write, mdr_load: bus.mdr_load, a_load: bus.a_load,
                  b_load: bus.b_load, aluout_load: bus.aluout_load, reg_write: bus.reg_write,
                  reg_dst: bus.reg_dst, mem_to_reg: bus.mem_to_reg, alu_src_a: bus.alu_src_a,
                  alu_src_b: bus.alu_src_b, alu_sel: bus.alu_sel, pc_source: bus.pc_source,
                  epc_load: bus.epc_load, cause_load: bus.cause_load, cause: bus.cause};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ctrl cyc=%0d got=%07h (st %0d) exp=%07h (st %0d)",
                         cyc, a, a.st, e, e.st);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One instruction. zsel/osel force the decisive zero/overflow flag
    // (-1 = random); abort_at is the cycle index at which reset is pulsed.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zsel, input int osel, input int abort_at);
        ph_t        ph[$];
        bit         fz, fo, ovf_trap;
        logic [1:0] cs;
        bit         r_legal, bne_legal;
        fz = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        fo = (osel < 0) ? 1'($urandom) : 1'(osel);
        cs = 2'b00;
        r_legal = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h26);
`ifdef MIPS_BNE_EN
        bne_legal = 1;
`else
        bne_legal = 0;
`endif
        for (int i = 0; i <= W; i++) ph.push_back('{FETCH, i == W});
        ph.push_back('{DECODE, 1});
        if (r_legal) begin
            ovf_trap = fo && (fn == 6'h20 || fn == 6'h22);
            ph.push_back('{EXEC, 1});
            if (ovf_trap) begin ph.push_back('{EXC, 1}); cs = 2'b10; end
            else ph.push_back('{RWB, 1});
        end else if (op == 6'h23) begin
            ph.push_back('{MEMADDR, 1});
            for (int i = 0; i <= W; i++) ph.push_back('{MEMREAD, i == W});
            ph.push_back('{MEMWB, 1});
        end else if (op == 6'h2B) begin
            ph.push_back('{MEMADDR, 1});
            for (int i = 0; i <= W; i++) ph.push_back('{MEMWRITE, i == W});
        end else if (op == 6'h04) begin
            ph.push_back('{BRANCH, 1});
        end else if (op == 6'h05 && bne_legal) begin
            ph.push_back('{BRANCH_NE, 1});
        end else if (op == 6'h02) begin
            ph.push_back('{JUMP, 1});
        end else if (op == 6'h08) begin
            ph.push_back('{ADDI_EX, 1});
            if (fo) begin ph.push_back('{EXC, 1}); cs = 2'b10; end
            else ph.push_back('{IWB, 1});
        end else begin
            ph.push_back('{EXC, 1});
            cs = 2'b01;
        end

        for (int i = 0; i < ph.size(); i++) begin
            bit z, o;
            tick();
            z = (ph[i].st == BRANCH || ph[i].st == BRANCH_NE) ? fz : 1'($urandom);
            o = (ph[i].st == EXEC || ph[i].st == ADDI_EX) ? fo : 1'($urandom);
            bus.opcode       = op;
            bus.funct        = fn;
            bus.alu_zero     = z;
            bus.alu_overflow = o;
            exp_q.push_back(exp_cw(ph[i].st, ph[i].fin, z, fn, cs));
            if (i == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                exp_q.push_back(rst_cw());
                return;
            end
        end
    endtask

    initial begin
        bus.opcode       = '0;
        bus.funct        = '0;
        bus.alu_zero     = 1'b0;
        bus.alu_overflow = 1'b0;
        tick();
        exp_q.push_back(rst_cw());
        tick();
        reset = 1'b0;
        exp_q.push_back(rst_cw());

        // Directed cases.
        run_instr(6'h23, 6'h00, -1, -1, -1);  // lw
        run_instr(6'h00, 6'h20, -1,  0, -1);  // add, no overflow
        run_instr(6'h00, 6'h20, -1,  1, -1);  // add, overflow trap
        run_instr(6'h00, 6'h22, -1,  1, -1);  // sub, overflow trap
        run_instr(6'h00, 6'h24, -1,  1, -1);  // and ignores overflow
        run_instr(6'h04, 6'h00,  1, -1, -1);  // beq taken
        run_instr(6'h04, 6'h00,  0, -1, -1);  // beq not taken
        run_instr(6'h3F, 6'h00, -1, -1, -1);  // illegal opcode
        run_instr(6'h05, 6'h00,  0, -1, -1);  // bne or illegal
        run_instr(6'h05, 6'h00,  1, -1, -1);
        run_instr(6'h00, 6'h21, -1, -1, -1);  // R-type, unknown funct
        run_instr(6'h08, 6'h00, -1,  1, -1);  // addi overflow
        run_instr(6'h08, 6'h00, -1,  0, -1);  // addi
        run_instr(6'h02, 6'h00, -1, -1, -1);  // j
        run_instr(6'h2B, 6'h00, -1, -1, W + 4); // sw, reset in 2nd MEMWRITE cycle
        run_instr(6'h2B, 6'h00, -1, -1, -1);  // sw complete

        // Random mix, occasionally aborted by reset.
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            int         sel, ab;
            fn  = 6'h00;
            sel = $urandom_range(0, 11);
            case (sel)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h24; end
                3: begin op = 6'h00; fn = 6'h26; end
                4: begin op = 6'h00; fn = 6'($urandom_range(0, 63)); end
                5: op = 6'h23;
                6: op = 6'h2B;
                7: op = 6'h04;
                8: op = 6'h05;
                9: op = 6'h02;
                10: op = 6'h08;
                default: begin op = 6'($urandom_range(0, 63)); fn = 6'($urandom_range(0, 63)); end
            endcase
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(op, fn, -1, -1, ab);
        end

        repeat (3) @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
